// File: rtl/vndecorrelator_pkg.sv
// Shared constants for the multi-channel von Neumann decorrelator.
package vndecorrelator_pkg;

  localparam logic [1:0] MODE_VN     = 2'b00;
  localparam logic [1:0] MODE_BYPASS = 2'b01;
  localparam logic [1:0] MODE_XOR    = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;  // treated as von Neumann

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_BITS = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/vn_pair_ch.sv
// One input channel: collects bit pairs and decides what (if anything) to emit.
module vn_pair_ch
  import vndecorrelator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       syn_in,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       emit,
  output logic       emit_bit,
  output logic       discard
);

  ctrl_state_t state, state_next;
  logic        a_bit;

  // Pair-state register; clear from the top is folded into state_next.
  always_ff @(posedge clk) begin
    if (reset) state <= CTRL_IDLE;
    else       state <= state_next;
  end

  // First bit of a pair is captured when leaving IDLE in a pairing mode.
  always_ff @(posedge clk) begin
    if (state == CTRL_IDLE && syn_in && !clear && mode != MODE_BYPASS)
      a_bit <= data_in;
  end

  // Next-state and emit decision for the current strobe.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_bit   = 1'b0;
    discard    = 1'b0;
    if (clear) begin
      state_next = CTRL_IDLE;
    end else if (syn_in) begin
      if (mode == MODE_BYPASS) begin
        emit       = 1'b1;
        emit_bit   = data_in;
        state_next = CTRL_IDLE;
      end else if (state == CTRL_IDLE) begin
        state_next = CTRL_BITS;
      end else begin
        state_next = CTRL_IDLE;
        if (mode == MODE_XOR) begin
          emit     = 1'b1;
          emit_bit = a_bit ^ data_in;
        end else if (a_bit != data_in) begin
          emit     = 1'b1;
          emit_bit = data_in;
        end else begin
          discard  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vndecorrelator_pack.sv
// Multi-channel decorrelator: per-channel pairing, word packer, output register, statistics.
module vndecorrelator_pack
  import vndecorrelator_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] data_in,
  input  logic [NUM_CH-1:0] syn_in,
  input  logic [1:0]        mode,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  discard_cnt,
  output logic [CNT_W-1:0]  overflow_cnt
);

  localparam int AW = WORD_W + NUM_CH;
  localparam int FW = $clog2(AW + 1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [1:0]        mode_reg;
  logic              mode_change;
  logic [NUM_CH-1:0] emit, emit_bit, discard;
  logic [WORD_W-1:0] acc, acc_next, word;
  logic [FW-1:0]     fill, fill_next, pos;
  logic [AW-1:0]     combined;
  logic              word_done;
  logic [CNT_W-1:0]  d_cnt;
  logic [WORD_W-1:0] word_p1;
  logic              vld_p1;

  assign mode_change = (mode != mode_reg);

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    vn_pair_ch u_ch (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in[i]),
      .syn_in   (syn_in[i]),
      .mode     (mode_reg),
      .clear    (mode_change),
      .emit     (emit[i]),
      .emit_bit (emit_bit[i]),
      .discard  (discard[i])
    );
  end

  // Packer: append emitted bits above the current fill, split off a full word.
  always_comb begin
    combined = AW'(acc);
    pos      = fill;
    d_cnt    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (emit[i]) begin
        combined = combined | (AW'(emit_bit[i]) << pos);
        pos      = pos + FW'(1);
      end
      d_cnt = d_cnt + CNT_W'(discard[i]);
    end
    word_done = (pos >= FW'(WORD_W));
    word      = combined[WORD_W-1:0];
    if (word_done) begin
      acc_next  = WORD_W'(combined >> WORD_W);
      fill_next = pos - FW'(WORD_W);
    end else begin
      acc_next  = combined[WORD_W-1:0];
      fill_next = pos;
    end
  end

  // Stage p0 -> p1: mode register, accumulator, completed-word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg <= MODE_VN;
      acc      <= '0;
      fill     <= '0;
      vld_p1   <= 1'b0;
    end else begin
      mode_reg <= mode;
      acc      <= acc_next;
      fill     <= fill_next;
      vld_p1   <= word_done;
    end
    word_p1 <= word;
  end

  // Stage p1 -> output: single-entry output register with overflow accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      overflow_cnt <= '0;
    end else if (vld_p1) begin
      if (!out_valid || out_ready) begin
        out_data  <= word_p1;
        out_valid <= 1'b1;
      end else begin
        overflow_cnt <= sat_add(overflow_cnt, CNT_W'(1));
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of discarded von Neumann pairs.
  always_ff @(posedge clk) begin
    if (reset) discard_cnt <= '0;
    else       discard_cnt <= sat_add(discard_cnt, d_cnt);
  end

endmodule
